// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler: picks one of NREQ requesters, owns the shared datapath mux select,
// and holds the grant for a burst of req_len beats on a valid/ready handshake.
module mux_rr_scheduler #(
    parameter int NREQ    = 6,
    parameter int SEL_W   = 3,
    parameter int BURST_W = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*BURST_W-1:0]   req_len,
    input  logic                      dp_ready,
    output logic [NREQ-1:0]           grant,
    output logic [SEL_W-1:0]          sel,
    output logic                      dp_valid,
    output logic                      busy,
    output logic                      burst_done
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                dp_valid_q, dp_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [BURST_W-1:0]  cnt_q, cnt_d;

    logic                found;
    logic [SEL_W-1:0]    win;
    logic [SEL_W-1:0]    idx;
    logic [BURST_W-1:0]  len_w;
    logic                beat;

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
        return (i == SEL_W'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Circular priority search starting at ptr; the previous winner sits at the bottom.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = next_idx(idx);
        end
    end

    assign len_w = req_len[win*BURST_W +: BURST_W];
    assign beat  = dp_valid_q && dp_ready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        dp_valid_d = dp_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_BUSY;
                    sel_d      = win;
                    grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    cnt_d      = (len_w == '0) ? BURST_W'(1) : len_w;
                    dp_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_BUSY: begin
                // A dropped request ends the burst exactly like a final beat.
                if (!req[sel_q] || (beat && cnt_q == BURST_W'(1))) begin
                    state_d    = S_IDLE;
                    grant_d    = '0;
                    dp_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    ptr_d      = next_idx(sel_q);
                    cnt_d      = '0;
                end else if (beat) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            dp_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            dp_valid_q <= dp_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant      = grant_q;
    assign sel        = sel_q;
    assign dp_valid   = dp_valid_q;
    assign busy       = busy_q;
    assign burst_done = done_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: a driver issues bursts and queues the expected winner and beat
// count from a transaction-level round-robin model; a monitor checks each observed burst.
module tb_mux_rr_scheduler;

    localparam int NREQ    = 6;
    localparam int SEL_W   = 3;
    localparam int BURST_W = 4;

    logic                     Clk = 1'b0;
    logic                     Reset = 1'b1;
    logic [NREQ-1:0]          req = '0;
    logic [NREQ*BURST_W-1:0]  req_len = '0;
    logic                     dp_ready = 1'b0;
    logic [NREQ-1:0]          grant;
    logic [SEL_W-1:0]         sel;
    logic                     dp_valid;
    logic                     busy;
    logic                     burst_done;

    typedef struct {
        int w;
        int beats;
        bit killed;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   ptr    = 0;

    mux_rr_scheduler #(.NREQ(NREQ), .SEL_W(SEL_W), .BURST_W(BURST_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req        (req),
        .req_len    (req_len),
        .dp_ready   (dp_ready),
        .grant      (grant),
        .sel        (sel),
        .dp_valid   (dp_valid),
        .busy       (busy),
        .burst_done (burst_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Model: first requester at or after ptr, wrapping around.
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++)
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic int len_of(input logic [NREQ*BURST_W-1:0] lens, input int w);
        int l;
        l = int'(lens[w*BURST_W +: BURST_W]);
        return (l == 0) ? 1 : l;
    endfunction

    // mode: 0 ready always high, 1 random ready with noisy req/req_len, 2 ready pattern 1,0,0,1.
    task automatic run_burst(input logic [NREQ-1:0] r, input logic [NREQ*BURST_W-1:0] lens,
                             input int mode, input int abort_k, input bit abort_rdy, input bit hold);
        int   w, beats, acc, pat_i;
        exp_t e;
        bit   pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        w = pick(r);
        beats = len_of(lens, w);
        e.w = w;
        e.beats = (abort_k > 0) ? abort_k + int'(abort_rdy) : beats;
        e.killed = 1'b0;
        sb.push_back(e);
        req = r;
        req_len = lens;
        dp_ready = 1'b0;
        @(negedge Clk);
        chk("grant_latency", int'(grant), 1 << w);
        acc = 0;
        pat_i = 0;
        forever begin
            if (abort_k > 0 && acc == abort_k) begin
                req[w] = 1'b0;
                dp_ready = abort_rdy;
                @(negedge Clk);
                acc += int'(abort_rdy);
                break;
            end
            case (mode)
                0: dp_ready = 1'b1;
                1: dp_ready = 1'($urandom_range(0, 1));
                default: dp_ready = (pat_i < 4) ? pat[pat_i] : 1'b1;
            endcase
            pat_i++;
            if (mode == 1) begin
                req_len = (NREQ*BURST_W)'($urandom);
                req = NREQ'($urandom) | (NREQ'(1) << w);
            end
            @(negedge Clk);
            if (dp_ready) acc++;
            if (acc == beats) break;
        end
        chk("end_busy", int'(busy), 0);
        chk("end_done", int'(burst_done), 1);
        ptr = (w + 1) % NREQ;
        dp_ready = 1'b0;
        if (!hold) begin
            req = '0;
            @(negedge Clk);
            chk("sel_hold_idle", int'(sel), w);
        end
    endtask

    // Monitor: tracks each burst from grant rising to grant falling.
    initial begin
        bit   in_b, beat, ended, killed;
        int   acc, gw;
        exp_t e;
        in_b = 1'b0;
        acc = 0;
        gw = 0;
        forever begin
            @(posedge Clk);
            beat = dp_valid && dp_ready;
            #1;
            ended = 1'b0;
            killed = 1'b0;
            if (in_b) begin
                if (beat) acc++;
                if (grant == '0) begin
                    ended = 1'b1;
                    in_b = 1'b0;
                    chk("exp_avail", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        killed = e.killed;
                        chk("winner", gw, e.w);
                        chk("beats", acc, e.beats);
                    end
                end else begin
                    chk("sel_stable", int'(sel), gw);
                    chk("dp_valid_hold", int'(dp_valid), 1);
                end
            end else if (grant != '0) begin
                in_b = 1'b1;
                acc = 0;
                gw = int'(sel);
            end
            chk("done_pulse", int'(burst_done), int'(ended && !killed));
            chk("busy_vs_grant", int'(busy), int'(grant != '0));
            chk("grant_is_onehot_sel", int'(grant), busy ? (1 << sel) : 0);
        end
    end

    initial begin
        exp_t e;
        logic [NREQ-1:0] r;
        logic [NREQ*BURST_W-1:0] lens;
        int w, b, ak;
        bit ar;

        // Reset held with every requester asserting.
        req = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("rst_grant", int'(grant), 0);
            chk("rst_sel", int'(sel), 0);
            chk("rst_dp_valid", int'(dp_valid), 0);
            chk("rst_busy", int'(busy), 0);
        end
        req = '0;
        Reset = 1'b0;
        ptr = 0;
        @(negedge Clk);

        // Single requester, three beats; then ptr=3 shows up in the next rotation.
        run_burst(6'b000100, 24'h000300, 0, 0, 1'b0, 1'b0);

        // All requesters, length 1, request held continuously.
        for (int i = 0; i < 7; i++)
            run_burst(6'b111111, 24'h111111, 0, 0, 1'b0, 1'b1);
        req = '0;
        @(negedge Clk);

        // Requester 5 with ready stalls; ptr wraps to 0 afterwards.
        run_burst(6'b100000, 24'h200000, 2, 0, 1'b0, 1'b0);

        // Requester 1, length 5, dropped after two beats.
        run_burst(6'b000010, 24'h000050, 0, 2, 1'b0, 1'b0);

        // Zero length yields exactly one beat.
        run_burst(6'b001000, 24'h000000, 0, 0, 1'b0, 1'b0);

        // Reset one beat into a four-beat burst from requester 3.
        e.w = 3; e.beats = 1; e.killed = 1'b1;
        sb.push_back(e);
        req = 6'b001000;
        req_len = 24'h004000;
        @(negedge Clk);
        dp_ready = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        dp_ready = 1'b0;
        @(negedge Clk);
        chk("rst_kill_grant", int'(grant), 0);
        chk("rst_kill_done", int'(burst_done), 0);
        chk("rst_kill_valid", int'(dp_valid), 0);
        Reset = 1'b0;
        req = '0;
        ptr = 0;
        @(negedge Clk);
        run_burst(6'b111111, 24'h111111, 0, 0, 1'b0, 1'b0);

        // Randomized bursts with stalls, aborts and input noise during the burst.
        for (int i = 0; i < 40; i++) begin
            r = NREQ'($urandom);
            if (r == '0) r = 6'b000001;
            lens = (NREQ*BURST_W)'($urandom);
            w = pick(r);
            b = len_of(lens, w);
            ak = 0;
            ar = 1'($urandom_range(0, 1));
            if (b >= 2 && $urandom_range(0, 3) == 0) ak = $urandom_range(1, b - 1);
            run_burst(r, lens, 1, ak, ar, 1'($urandom_range(0, 1)));
        end
        req = '0;
        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
